// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: EX-stage ALU-op decode plus an iterative radix-2
// multiply/divide unit with HI/LO registers and a pipeline stall handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for mult/div; mthi/mtlo write HI/LO here
// S_CALC | one shift-add (mul) or restoring shift-subtract (div) step
// S_FIX  | sign correction, HI/LO write, done pulse on the next cycle
module alu_ctrl_mdu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       alu_ctr,
   input  logic [5:0]       func,
   input  logic             md_en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] md_out,
   output logic             md_sel,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_SLT  = 4'b0110;
   localparam logic [3:0] OP_SLTU = 4'b0111;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_NOP  = 4'b1111;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               op_div;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   mcand;

   logic               is_r;
   logic               is_muldiv;
   logic               is_mdu;
   logic               start;
   logic               mfhi_sel;
   logic               mflo_sel;
   logic               mthi_wr;
   logic               mtlo_wr;
   logic               op_signed;
   logic               sgn_a;
   logic               sgn_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi_nxt;
   logic [WIDTH-1:0]   mul_lo_nxt;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ok;
   logic [WIDTH-1:0]   div_hi_nxt;
   logic [WIDTH-1:0]   div_lo_nxt;

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Main-control / func decode into the ALU operation select
   always_comb begin
      alu_op = OP_NOP;
      case (alu_ctr)
         2'b00: alu_op = OP_ADD;
         2'b01: alu_op = OP_SUB;
         2'b11: alu_op = OP_OR;
         default: begin
            case (func)
               6'b100000, 6'b100001: alu_op = OP_ADD;
               6'b100010, 6'b100011: alu_op = OP_SUB;
               6'b100100:            alu_op = OP_AND;
               6'b100101:            alu_op = OP_OR;
               6'b100110:            alu_op = OP_XOR;
               6'b100111:            alu_op = OP_NOR;
               6'b101010:            alu_op = OP_SLT;
               6'b101011:            alu_op = OP_SLTU;
               6'b000000, 6'b000100: alu_op = OP_SLL;
               6'b000010, 6'b000110: alu_op = OP_SRL;
               6'b000011, 6'b000111: alu_op = OP_SRA;
               default:              alu_op = OP_NOP;
            endcase
         end
      endcase
   end

   // MDU instruction classification, start and stall handshake
   always_comb begin
      is_r      = (alu_ctr == 2'b10);
      is_muldiv = is_r & ((func == F_MULT) | (func == F_MULTU) |
                          (func == F_DIV)  | (func == F_DIVU));
      is_mdu    = is_muldiv | (is_r & ((func == F_MFHI) | (func == F_MTHI) |
                                       (func == F_MFLO) | (func == F_MTLO)));
      start     = md_en & is_muldiv & ~busy;
      stall     = md_en & is_mdu & busy;
      mfhi_sel  = md_en & is_r & (func == F_MFHI);
      mflo_sel  = md_en & is_r & (func == F_MFLO);
      mthi_wr   = md_en & is_r & (func == F_MTHI) & ~busy;
      mtlo_wr   = md_en & is_r & (func == F_MTLO) & ~busy;
      md_sel    = mfhi_sel | mflo_sel;
      md_out    = '0;
      if (mfhi_sel)
         md_out = hi;
      else if (mflo_sel)
         md_out = lo;
   end

   // Operand magnitudes for signed ops (func[0]=0 selects the signed variant)
   always_comb begin
      op_signed = ~func[0];
      sgn_a     = op_signed & a[WIDTH-1];
      sgn_b     = op_signed & b[WIDTH-1];
      mag_a     = sgn_a ? -a : a;
      mag_b     = sgn_b ? -b : b;
   end

   // One iteration step: acc_lo holds the multiplier (mul) or the dividend
   // being shifted into the remainder (div); mcand is multiplicand/divisor
   always_comb begin
      mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
      mul_hi_nxt = mul_sum[WIDTH:1];
      mul_lo_nxt = {mul_sum[0], acc_lo[WIDTH-1:1]};
      div_shift  = {acc_hi, acc_lo[WIDTH-1]};
      div_diff   = div_shift - {1'b0, mcand};
      div_ok     = ~div_diff[WIDTH];
      div_hi_nxt = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_lo_nxt = {acc_lo[WIDTH-2:0], div_ok};
   end

   // Sign correction; divide by zero forces an all-ones quotient while the
   // remainder path naturally ends up holding the original dividend
   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = neg_q ? -prod : prod;
      quo_fix  = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
      rem_fix  = neg_r ? -acc_hi : acc_hi;
   end

   // MDU sequencer, HI/LO registers and busy/done flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         op_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         mcand    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_CALC;
                  busy     <= 1'b1;
                  cnt      <= '0;
                  op_div   <= func[1];
                  neg_q    <= sgn_a ^ sgn_b;
                  neg_r    <= sgn_a;
                  div_zero <= (b == '0);
                  acc_hi   <= '0;
                  acc_lo   <= func[1] ? mag_a : mag_b;
                  mcand    <= func[1] ? mag_b : mag_a;
               end else begin
                  if (mthi_wr)
                     hi <= a;
                  if (mtlo_wr)
                     lo <= a;
               end
            end
            S_CALC: begin
               acc_hi <= op_div ? div_hi_nxt : mul_hi_nxt;
               acc_lo <= op_div ? div_lo_nxt : mul_lo_nxt;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST)
                  state <= S_FIX;
            end
            S_FIX: begin
               if (op_div) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// tb_alu_ctrl_mdu: scoreboard bench for the ALU decode and MDU.
module tb_alu_ctrl_mdu;

   localparam int W = 32;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   logic         clk;
   logic         reset;
   logic [1:0]   alu_ctr;
   logic [5:0]   func;
   logic         md_en;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   alu_op;
   logic [W-1:0] md_out;
   logic         md_sel;
   logic         stall;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   logic [2*W-1:0] sb_q[$];

   typedef struct {
      logic [1:0] c;
      logic [5:0] f;
      logic [3:0] op;
   } dec_t;

   dec_t dec_tab[$];

   alu_ctrl_mdu #(.WIDTH(W), .CNT_W(6)) dut (
      .clk     (clk),
      .reset   (reset),
      .alu_ctr (alu_ctr),
      .func    (func),
      .md_en   (md_en),
      .a       (a),
      .b       (b),
      .alu_op  (alu_op),
      .md_out  (md_out),
      .md_sel  (md_sel),
      .stall   (stall),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference results from plain language arithmetic: {HI, LO}
   function automatic logic [2*W-1:0] md_model(input logic [5:0] f, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      logic [63:0]        p;
      int                 ix;
      int                 iy;
      sx = {{32{x[W-1]}}, x};
      sy = {{32{y[W-1]}}, y};
      ix = x;
      iy = y;
      md_model = '0;
      case (f)
         F_MULT:  begin p = sx * sy; md_model = p; end
         F_MULTU: begin p = {32'b0, x} * {32'b0, y}; md_model = p; end
         F_DIV: begin
            if (y == 0)
               md_model = {x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
               md_model = {32'h0, 32'h8000_0000};
            else
               md_model = {32'(ix % iy), 32'(ix / iy)};
         end
         F_DIVU: begin
            if (y == 0)
               md_model = {x, 32'hFFFF_FFFF};
            else
               md_model = {x % y, x / y};
         end
         default: md_model = '0;
      endcase
   endfunction

   task automatic idle_inputs();
      md_en   = 1'b0;
      alu_ctr = 2'b00;
      func    = 6'b000000;
   endtask

   // Issue one mult/div, scramble operands while it runs, check timing and result
   task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] x,
                         input logic [W-1:0] y);
      int             lat;
      int             nbusy;
      bit             seen;
      logic [2*W-1:0] exp;
      @(posedge clk); #1;
      md_en = 1'b1; alu_ctr = 2'b10; func = f; a = x; b = y;
      sb_q.push_back(md_model(f, x, y));
      @(posedge clk); #1;
      idle_inputs();
      a = $urandom; b = $urandom;
      lat = 1; nbusy = 0; seen = 0;
      while (lat <= 60 && !seen) begin
         if (busy) nbusy++;
         if (done) seen = 1;
         else begin
            @(posedge clk); #1;
            lat++;
            a = $urandom; b = $urandom;
         end
      end
      check_val({tag, "_done_seen"}, 64'(seen), 64'd1);
      if (seen) begin
         exp = sb_q.pop_front();
         check_val({tag, "_hi"}, 64'(hi), 64'(exp[2*W-1:W]));
         check_val({tag, "_lo"}, 64'(lo), 64'(exp[W-1:0]));
         check_val({tag, "_latency"}, 64'(lat), 64'(W + 2));
         check_val({tag, "_busy_cycles"}, 64'(nbusy), 64'(W + 1));
         check_val({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      int             k;
      int             done_k;
      int             stall_bad;
      int             n_done;
      logic [2*W-1:0] exp;
      logic [5:0]     rf;
      logic [5:0]     mdf[4];

      idle_inputs();
      a = '0; b = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_hi", 64'(hi), 64'd0);
      check_val("rst_lo", 64'(lo), 64'd0);
      check_val("rst_stall", 64'(stall), 64'd0);
      check_val("rst_md_sel", 64'(md_sel), 64'd0);
      check_val("rst_md_out", 64'(md_out), 64'd0);
      check_val("rst_alu_op", 64'(alu_op), 64'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      dec_tab.push_back('{2'b00, 6'b101010, 4'b0000});
      dec_tab.push_back('{2'b01, 6'b100100, 4'b0001});
      dec_tab.push_back('{2'b11, 6'b000000, 4'b0011});
      dec_tab.push_back('{2'b10, 6'b100000, 4'b0000});
      dec_tab.push_back('{2'b10, 6'b100001, 4'b0000});
      dec_tab.push_back('{2'b10, 6'b100010, 4'b0001});
      dec_tab.push_back('{2'b10, 6'b100011, 4'b0001});
      dec_tab.push_back('{2'b10, 6'b100100, 4'b0010});
      dec_tab.push_back('{2'b10, 6'b100101, 4'b0011});
      dec_tab.push_back('{2'b10, 6'b100110, 4'b0100});
      dec_tab.push_back('{2'b10, 6'b100111, 4'b0101});
      dec_tab.push_back('{2'b10, 6'b101010, 4'b0110});
      dec_tab.push_back('{2'b10, 6'b101011, 4'b0111});
      dec_tab.push_back('{2'b10, 6'b000000, 4'b1000});
      dec_tab.push_back('{2'b10, 6'b000100, 4'b1000});
      dec_tab.push_back('{2'b10, 6'b000010, 4'b1001});
      dec_tab.push_back('{2'b10, 6'b000110, 4'b1001});
      dec_tab.push_back('{2'b10, 6'b000011, 4'b1010});
      dec_tab.push_back('{2'b10, 6'b000111, 4'b1010});
      dec_tab.push_back('{2'b10, 6'b001000, 4'b1111});
      dec_tab.push_back('{2'b10, F_MULT,    4'b1111});
      dec_tab.push_back('{2'b10, F_MFHI,    4'b1111});
      dec_tab.push_back('{2'b10, F_DIVU,    4'b1111});
      foreach (dec_tab[i]) begin
         alu_ctr = dec_tab[i].c;
         func    = dec_tab[i].f;
         #1;
         check_val($sformatf("decode_%b_%b", dec_tab[i].c, dec_tab[i].f),
                   64'(alu_op), 64'(dec_tab[i].op));
      end
      idle_inputs();

      // mthi/mtlo write, mfhi/mflo read back through md_out
      @(posedge clk); #1;
      md_en = 1'b1; alu_ctr = 2'b10; func = F_MTHI; a = 32'hA5A5_1234;
      @(posedge clk); #1;
      func = F_MTLO; a = 32'h0F0F_5678;
      @(posedge clk); #1;
      func = F_MFHI; a = '0;
      #1;
      check_val("mthi_hi", 64'(hi), 64'h0000_0000_A5A5_1234);
      check_val("mtlo_lo", 64'(lo), 64'h0000_0000_0F0F_5678);
      check_val("mfhi_md_out", 64'(md_out), 64'h0000_0000_A5A5_1234);
      check_val("mfhi_md_sel", 64'(md_sel), 64'd1);
      check_val("mfhi_stall_idle", 64'(stall), 64'd0);
      check_val("mthi_no_busy", 64'(busy), 64'd0);
      func = F_MFLO;
      #1;
      check_val("mflo_md_out", 64'(md_out), 64'h0000_0000_0F0F_5678);
      idle_inputs();

      run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op("mult_neg3x5", F_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
      run_op("div_neg7_2", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
      run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu_zero", F_DIVU, 32'h1234_5678, 32'h0000_0000);
      run_op("div_zero_neg", F_DIV, 32'hFFFF_FF00, 32'h0000_0000);
      run_op("div_pos_neg", F_DIV, 32'h0000_0064, 32'hFFFF_FFF9);

      mdf[0] = F_MULT; mdf[1] = F_MULTU; mdf[2] = F_DIV; mdf[3] = F_DIVU;
      for (int i = 0; i < 4; i++) begin
         rf = mdf[$urandom_range(0, 3)];
         run_op($sformatf("rand%0d", i), rf, $urandom, $urandom_range(0, 2) == 0 ?
                32'($urandom_range(1, 300)) : $urandom);
      end

      // Hazard: second MULT while busy is ignored, MFLO stalls until done
      @(posedge clk); #1;
      md_en = 1'b1; alu_ctr = 2'b10; func = F_MULT; a = 32'h0000_0007; b = 32'h0000_0009;
      sb_q.push_back(md_model(F_MULT, 32'h0000_0007, 32'h0000_0009));
      done_k = 0; stall_bad = 0;
      for (k = 1; k <= 60 && done_k == 0; k++) begin
         @(posedge clk); #1;
         if (k == 3) begin
            md_en = 1'b1; func = F_MULT; a = 32'h0000_0064; b = 32'h0000_0064;
         end else if (k >= 5) begin
            md_en = 1'b1; func = F_MFLO; a = '0; b = '0;
         end else begin
            md_en = 1'b0;
         end
         #1;
         if (k == 3) check_val("hz_stall_second_mult", 64'(stall), 64'd1);
         if (done) done_k = k;
         else if (k >= 5 && stall !== 1'b1) stall_bad++;
      end
      check_val("hz_stall_until_done", 64'(stall_bad), 64'd0);
      check_val("hz_done_latency", 64'(done_k), 64'(W + 2));
      check_val("hz_stall_at_done", 64'(stall), 64'd0);
      exp = sb_q.pop_front();
      check_val("hz_lo", 64'(lo), 64'(exp[W-1:0]));
      check_val("hz_md_out_mflo", 64'(md_out), 64'(exp[W-1:0]));
      idle_inputs();
      n_done = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check_val("hz_second_mult_ignored", 64'(n_done), 64'd0);

      // Reset in the middle of CALC (cnt == 10)
      check_val("pre_abort_hi_nonzero", 64'(hi != '0 || lo != '0), 64'd1);
      @(posedge clk); #1;
      md_en = 1'b1; alu_ctr = 2'b10; func = F_DIVU; a = 32'h0001_0000; b = 32'h0000_0003;
      for (int i = 1; i <= 11; i++) begin
         @(posedge clk); #1;
         idle_inputs();
      end
      check_val("abort_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_val("abort_busy", 64'(busy), 64'd0);
      check_val("abort_hi", 64'(hi), 64'd0);
      check_val("abort_lo", 64'(lo), 64'd0);
      n_done = 0;
      for (int i = 0; i < 45; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check_val("abort_no_done", 64'(n_done), 64'd0);
      check_val("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
